// File: rtl/carfield_regbus_resp_demux.sv
// Register-bus request router: decodes one upstream request to a target window,
// forwards it and returns the response. Optional forward-phase timeout via CARFIELD_REGBUS_TIMEOUT_EN.
module carfield_regbus_resp_demux #(
    parameter int NUM_TGT = 4,
    parameter int ADDR_W = 48,
    parameter int DATA_W = 32,
    parameter logic [NUM_TGT-1:0][ADDR_W-1:0] TGT_BASE = {ADDR_W'(32'h21003000), ADDR_W'(32'h21002000),
                                                          ADDR_W'(32'h21001000), ADDR_W'(32'h21000000)},
    parameter logic [NUM_TGT-1:0][ADDR_W-1:0] TGT_SIZE = {NUM_TGT{ADDR_W'(32'h1000)}},
    parameter logic [NUM_TGT-1:0] TGT_EN = {NUM_TGT{1'b1}},
    parameter int TO_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    input  logic                      in_write_i,
    input  logic [ADDR_W-1:0]         in_addr_i,
    input  logic [DATA_W-1:0]         in_wdata_i,
    input  logic [DATA_W/8-1:0]       in_wstrb_i,
    output logic                      in_ready_o,
    output logic                      in_error_o,
    output logic [DATA_W-1:0]         in_rdata_o,
    output logic [NUM_TGT-1:0]        out_valid_o,
    input  logic [NUM_TGT-1:0]        out_ready_i,
    input  logic [NUM_TGT-1:0]        out_error_i,
    output logic [ADDR_W-1:0]         out_addr_o,
    output logic [DATA_W-1:0]         out_wdata_o,
    output logic [DATA_W/8-1:0]       out_wstrb_o,
    output logic                      out_write_o,
    input  logic [NUM_TGT*DATA_W-1:0] out_rdata_i,
    output logic                      timeout_o
);

    localparam int IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                write_q, write_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                fwd_ready;
    logic                fwd_to;

    if (TO_CYCLES < 1) begin : g_to_check
        $error("TO_CYCLES must be at least 1");
    end

    // Windows compared one bit wider so base+size cannot wrap; descending scan lets the lowest index win.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if (TGT_EN[i] &&
                ({1'b0, in_addr_i} >= {1'b0, TGT_BASE[i]}) &&
                ({1'b0, in_addr_i} <  ({1'b0, TGT_BASE[i]} + {1'b0, TGT_SIZE[i]}))) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    assign fwd_ready = (state_q == ST_FWD) && out_ready_i[sel_q];

`ifdef CARFIELD_REGBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    // Ready on the terminal cycle still wins over the timeout.
    assign fwd_to = (state_q == ST_FWD) && !out_ready_i[sel_q] && (cnt_q == CNT_W'(TO_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == ST_FWD) && !out_ready_i[sel_q]) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= fwd_to;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign fwd_to    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid_i) state_d = dec_hit ? ST_FWD : ST_RESP;
            ST_FWD:  if (fwd_ready || fwd_to) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        write_d = write_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if ((state_q == ST_IDLE) && in_valid_i) begin
            addr_d  = in_addr_i;
            wdata_d = in_wdata_i;
            wstrb_d = in_wstrb_i;
            write_d = in_write_i;
            sel_d   = dec_idx;
            rdata_d = '0;
            err_d   = !dec_hit;
        end else if (fwd_ready) begin
            rdata_d = out_rdata_i[sel_q*DATA_W +: DATA_W];
            err_d   = out_error_i[sel_q];
        end else if (fwd_to) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        out_valid_o = '0;
        if (state_q == ST_FWD) out_valid_o[sel_q] = 1'b1;
        out_addr_o  = addr_q;
        out_wdata_o = wdata_q;
        out_wstrb_o = wstrb_q;
        out_write_o = write_q;
        in_ready_o  = (state_q == ST_RESP);
        in_rdata_o  = (state_q == ST_RESP) ? rdata_q : '0;
        in_error_o  = (state_q == ST_RESP) ? err_q : 1'b0;
    end

endmodule
